maxima_reduction_ctrl: RTL

//  Sequences the find_maxima comparator-reduction tree once per FFT frame, one pass per frequency band.

---
 rtl/maxima_reduction_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/maxima_reduction_ctrl.sv
// Per-frame sequencer for the find_maxima reduction tree: one load/wait/emit pass per band,
// streaming one {index, magnitude} peak record per band downstream.
module maxima_reduction_ctrl #(
  parameter int          NUM_BANDS = 4,
  parameter int          BAND_W    = 2,
  parameter int          TREE_LAT  = 11,
  parameter int          TIMEOUT   = 16,
  parameter logic [15:0] THRESH    = 16'd64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_valid,
  output logic              frame_ready,
  output logic [BAND_W-1:0] band_sel,
  output logic              red_load,
  input  logic              red_active,
  input  logic [24:0]       red_result,
  output logic              peak_valid,
  input  logic              peak_ready,
  output logic [24:0]       peak_data,
  output logic [BAND_W-1:0] peak_band,
  output logic              peak_hit,
  output logic              peak_last,
  output logic              busy,
  output logic [15:0]       frame_count,
  output logic              err_timeout
);

  // A timeout shorter than the tree latency would abort every pass, so clamp it.
  localparam int                  LIMIT     = (TIMEOUT > TREE_LAT) ? TIMEOUT : TREE_LAT + 1;
  localparam int                  TIMER_W   = $clog2(LIMIT) + 1;
  localparam logic [TIMER_W-1:0]  TIMER_MAX = TIMER_W'(LIMIT - 1);
  localparam logic [BAND_W-1:0]   LAST_BAND = BAND_W'(NUM_BANDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_EMIT = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [TIMER_W-1:0] timer_r;
  logic               accept_s;
  logic               handshake_s;
  logic               timed_out_s;
  logic               last_band_s;

  // Index 0 is the zeroed DC bin and can never be a genuine peak.
  function automatic logic is_hit(input logic [24:0] rec);
    return (rec[15:0] >= THRESH) && (rec[24:16] != 9'd0);
  endfunction

  assign last_band_s = (band_sel == LAST_BAND);

  // Next-state decode and per-state event strobes
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    handshake_s  = 1'b0;
    timed_out_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        accept_s = frame_valid && frame_ready;
        if (accept_s) begin
          state_next_s = S_LOAD;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_LOAD: begin
        state_next_s = S_WAIT;
      end
      S_WAIT: begin
        if (red_active) begin
          state_next_s = S_EMIT;
        end else if (timer_r == TIMER_MAX) begin
          timed_out_s  = 1'b1;
          state_next_s = S_EMIT;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_EMIT: begin
        handshake_s = peak_valid && peak_ready;
        if (handshake_s) begin
          state_next_s = last_band_s ? S_IDLE : S_LOAD;
        end else begin
          state_next_s = S_EMIT;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered outputs, band/timer bookkeeping and peak capture
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_ready <= 1'b1;
      busy        <= 1'b0;
      red_load    <= 1'b0;
      peak_valid  <= 1'b0;
      band_sel    <= '0;
      timer_r     <= '0;
      peak_data   <= 25'd0;
      peak_band   <= '0;
      peak_hit    <= 1'b0;
      peak_last   <= 1'b0;
      frame_count <= 16'd0;
      err_timeout <= 1'b0;
    end else begin
      frame_ready <= (state_next_s == S_IDLE);
      busy        <= (state_next_s != S_IDLE);
      red_load    <= (state_next_s == S_LOAD);
      peak_valid  <= (state_next_s == S_EMIT);

      if (state_r == S_LOAD) begin
        timer_r <= '0;
      end else if (state_r == S_WAIT) begin
        timer_r <= timer_r + TIMER_W'(1);
      end

      // A late red_active in the timeout cycle still counts as a valid answer.
      if ((state_r == S_WAIT) && red_active) begin
        peak_data <= red_result;
        peak_hit  <= is_hit(red_result);
        peak_band <= band_sel;
        peak_last <= last_band_s;
      end else if (timed_out_s) begin
        peak_data   <= 25'd0;
        peak_hit    <= 1'b0;
        peak_band   <= band_sel;
        peak_last   <= last_band_s;
        err_timeout <= 1'b1;
      end

      if (accept_s) begin
        band_sel <= '0;
      end else if (handshake_s) begin
        band_sel <= last_band_s ? '0 : band_sel + BAND_W'(1);
      end

      if (handshake_s && last_band_s) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule
